// File: rtl/game_pkg.sv
`default_nettype none
//============================================================================
// Module      : game_pkg
// Description : Shared types, constants and BCD/seven-segment helpers for
//               the countdown game.
// Revision    : 1.0 - initial release
//============================================================================
package game_pkg;

  typedef enum logic [1:0] {
    SET   = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } game_state_t;

  // MM:SS held as four BCD digits
  typedef struct packed {
    logic [3:0] m1;
    logic [3:0] m0;
    logic [3:0] s1;
    logic [3:0] s0;
  } bcd_time_t;

  localparam logic [7:0] SEG_BLANK  = 8'hFF;
  localparam bcd_time_t  c_TIME_MAX = 16'h9959;

  // Active-low segments {g,f,e,d,c,b,a}; hex digits use the usual glyphs
  function automatic logic [6:0] segDecode(input logic [3:0] digit);
    case (digit)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  // Elaboration-time conversion of a seconds count to MM:SS, clamped to 99:59
  function automatic bcd_time_t secondsToBcd(input int secs);
    bcd_time_t r;
    int mins;
    int rem;
    mins = secs / 60;
    rem  = secs % 60;
    if (mins > 99) begin
      r = c_TIME_MAX;
    end else begin
      r.m1 = 4'(mins / 10);
      r.m0 = 4'(mins % 10);
      r.s1 = 4'(rem / 10);
      r.s0 = 4'(rem % 10);
    end
    return r;
  endfunction

  function automatic logic bcdIsZero(input bcd_time_t t);
    return (t == '0);
  endfunction

  // +1 s with 59->00 carry into minutes; saturates at 99:59
  function automatic bcd_time_t bcdInc(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t != c_TIME_MAX) begin
      if (t.s0 != 4'd9) begin
        r.s0 = t.s0 + 4'd1;
      end else begin
        r.s0 = 4'd0;
        if (t.s1 != 4'd5) begin
          r.s1 = t.s1 + 4'd1;
        end else begin
          r.s1 = 4'd0;
          if (t.m0 != 4'd9) begin
            r.m0 = t.m0 + 4'd1;
          end else begin
            r.m0 = 4'd0;
            r.m1 = t.m1 + 4'd1;
          end
        end
      end
    end
    return r;
  endfunction

  // -1 s with 00->59 borrow from minutes; saturates at 00:00
  function automatic bcd_time_t bcdDec(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t != '0) begin
      if (t.s0 != 4'd0) begin
        r.s0 = t.s0 - 4'd1;
      end else begin
        r.s0 = 4'd9;
        if (t.s1 != 4'd0) begin
          r.s1 = t.s1 - 4'd1;
        end else begin
          r.s1 = 4'd5;
          if (t.m0 != 4'd0) begin
            r.m0 = t.m0 - 4'd1;
          end else begin
            r.m0 = 4'd9;
            r.m1 = t.m1 - 4'd1;
          end
        end
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/countdown_game_if.sv
`default_nettype none
//============================================================================
// Module      : countdown_game_if
// Description : Board-facing bundle: three push-buttons in, multiplexed
//               seven-segment display out.
// Revision    : 1.0 - initial release
//============================================================================
interface countdown_game_if;
  logic       btnS;
  logic       btnU;
  logic       btnD;
  logic [7:0] seg;
  logic [3:0] an;

  // Board / stimulus side
  modport master (output btnS, btnU, btnD, input seg, an);
  // Game logic side
  modport slave  (input btnS, btnU, btnD, output seg, an);
endinterface
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
//============================================================================
// Module      : btn_debounce
// Description : Two-flop synchronizer, stability-count debouncer and
//               single-cycle rising-edge press pulse.
// Revision    : 1.0 - initial release
//============================================================================
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic i_btnRaw,
  output logic      o_press
);

  localparam int              c_CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]         r_sync;
  logic [c_CNT_W-1:0] r_stableCnt;
  logic               r_level;
  logic               r_levelDly;

  // Synchronize, then accept a new level only after it has differed from the
  // current one for DEBOUNCE_CYCLES consecutive cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync      <= 2'b00;
      r_stableCnt <= '0;
      r_level     <= 1'b0;
      r_levelDly  <= 1'b0;
    end else begin
      r_sync     <= {r_sync[0], i_btnRaw};
      r_levelDly <= r_level;
      if (r_sync[1] == r_level) begin
        r_stableCnt <= '0;
      end else if (r_stableCnt == c_CNT_MAX) begin
        r_level     <= r_sync[1];
        r_stableCnt <= '0;
      end else begin
        r_stableCnt <= r_stableCnt + c_CNT_W'(1);
      end
    end
  end

  // One pulse per accepted press; holding the button does not repeat
  assign o_press = r_level & ~r_levelDly;

endmodule
`default_nettype wire

// File: rtl/countdown_game.sv
`default_nettype none
//============================================================================
// Module      : countdown_game
// Description : MM:SS countdown timer with preset buttons, 1 Hz tick,
//               blinking expiry display and 4-digit multiplexed output.
// Revision    : 1.0 - initial release
//============================================================================
module countdown_game
  import game_pkg::*;
#(
  parameter int CLK_HZ          = 100_000_000,
  parameter int REFRESH_DIV     = 100_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int START_SECONDS   = 30
) (
  input  wire logic         Clk100Mhz,
  input  wire logic         rst_n,
  countdown_game_if.slave   bus
);

  localparam int                 c_TICK_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [c_TICK_W-1:0] c_TICK_MAX  = c_TICK_W'(CLK_HZ - 1);
  localparam logic [c_TICK_W-1:0] c_TICK_HALF = c_TICK_W'(CLK_HZ / 2);
  localparam int                 c_REF_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [c_REF_W-1:0] c_REF_MAX  = c_REF_W'(REFRESH_DIV - 1);
  localparam bcd_time_t          c_START    = secondsToBcd(START_SECONDS);

  logic w_pS;
  logic w_pU;
  logic w_pD;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbS (
    .clk(Clk100Mhz), .rst_n(rst_n), .i_btnRaw(bus.btnS), .o_press(w_pS)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbU (
    .clk(Clk100Mhz), .rst_n(rst_n), .i_btnRaw(bus.btnU), .o_press(w_pU)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbD (
    .clk(Clk100Mhz), .rst_n(rst_n), .i_btnRaw(bus.btnD), .o_press(w_pD)
  );

  game_state_t         r_state;
  game_state_t         w_stateNext;
  bcd_time_t           r_time;
  bcd_time_t           w_timeNext;
  bcd_time_t           r_preset;
  bcd_time_t           w_presetNext;
  logic                w_tickClr;
  logic [c_TICK_W-1:0] r_tickCnt;
  logic                w_tickWrap;
  logic [c_REF_W-1:0]  r_refCnt;
  logic [1:0]          r_scanIdx;
  logic [3:0]          w_digit;
  logic                w_blank;
  logic [7:0]          r_seg;
  logic [3:0]          r_an;

  assign w_tickWrap = (r_tickCnt == c_TICK_MAX);

  // One-second prescaler: frozen while paused, also paces the expiry blink
  always_ff @(posedge Clk100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_tickCnt <= '0;
    end else if (w_tickClr) begin
      r_tickCnt <= '0;
    end else if (r_state != PAUSE) begin
      r_tickCnt <= w_tickWrap ? '0 : r_tickCnt + c_TICK_W'(1);
    end
  end

  // Game state, current time and the preset restored after expiry
  always_ff @(posedge Clk100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= SET;
      r_time   <= c_START;
      r_preset <= c_START;
    end else begin
      r_state  <= w_stateNext;
      r_time   <= w_timeNext;
      r_preset <= w_presetNext;
    end
  end

  // Next state and time; select outranks up/down in every state
  always_comb begin
    w_stateNext  = r_state;
    w_timeNext   = r_time;
    w_presetNext = r_preset;
    w_tickClr    = 1'b0;
    case (r_state)
      SET: begin
        if (w_pS) begin
          if (!bcdIsZero(r_time)) begin
            w_presetNext = r_time;
            w_tickClr    = 1'b1;
            w_stateNext  = RUN;
          end
        end else if (w_pU && !w_pD) begin
          w_timeNext = bcdInc(r_time);
        end else if (w_pD && !w_pU) begin
          w_timeNext = bcdDec(r_time);
        end
      end
      RUN: begin
        // A tick that expires the timer wins over a simultaneous pause
        if (w_tickWrap) begin
          w_timeNext = bcdDec(r_time);
          if (bcdIsZero(w_timeNext)) begin
            w_stateNext = DONE;
          end else if (w_pS) begin
            w_stateNext = PAUSE;
          end
        end else if (w_pS) begin
          w_stateNext = PAUSE;
        end
      end
      PAUSE: begin
        if (w_pS) begin
          w_tickClr   = 1'b1;
          w_stateNext = RUN;
        end
      end
      DONE: begin
        if (w_pS) begin
          w_timeNext  = r_preset;
          w_stateNext = SET;
        end
      end
      default: w_stateNext = SET;
    endcase
  end

  // Digit scan: advance one position every REFRESH_DIV cycles
  always_ff @(posedge Clk100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_refCnt  <= '0;
      r_scanIdx <= 2'd0;
    end else if (r_refCnt == c_REF_MAX) begin
      r_refCnt  <= '0;
      r_scanIdx <= r_scanIdx + 2'd1;
    end else begin
      r_refCnt <= r_refCnt + c_REF_W'(1);
    end
  end

  // Index 0 is the rightmost (seconds units) digit
  always_comb begin
    w_digit = r_time.s0;
    case (r_scanIdx)
      2'd0:    w_digit = r_time.s0;
      2'd1:    w_digit = r_time.s1;
      2'd2:    w_digit = r_time.m0;
      default: w_digit = r_time.m1;
    endcase
  end

  // Expired display is dark for the second half of every second
  assign w_blank = (r_state == DONE) && (r_tickCnt >= c_TICK_HALF);

  // Registered segment/anode drive; dp on digit 2 forms the colon
  always_ff @(posedge Clk100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_seg <= SEG_BLANK;
      r_an  <= 4'b1111;
    end else if (w_blank) begin
      r_seg <= SEG_BLANK;
      r_an  <= 4'b1111;
    end else begin
      r_seg <= {(r_scanIdx != 2'd2), segDecode(w_digit)};
      r_an  <= ~(4'b0001 << r_scanIdx);
    end
  end

  assign bus.seg = r_seg;
  assign bus.an  = r_an;

endmodule
`default_nettype wire

// File: tb/tb_countdown_game.sv
`timescale 1ns/1ps
`default_nettype none
//============================================================================
// Module      : tb_countdown_game
// Description : Directed self-checking bench for countdown_game with a fast
//               clock map (100 cycles per second).
// Revision    : 1.0 - initial release
//============================================================================
module tb_countdown_game;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc         = 0;
  int   vectors     = 0;
  int   miscompares = 0;
  int   lastEdge    = 0;

  countdown_game_if bus ();
  countdown_game_if bus2 ();

  countdown_game #(
    .CLK_HZ(100), .REFRESH_DIV(4), .DEBOUNCE_CYCLES(3), .START_SECONDS(30)
  ) dut (
    .Clk100Mhz(clk), .rst_n(rst_n), .bus(bus)
  );

  // Second instance preset to the top of the range
  countdown_game #(
    .CLK_HZ(100), .REFRESH_DIV(4), .DEBOUNCE_CYCLES(3), .START_SECONDS(5999)
  ) dut2 (
    .Clk100Mhz(clk), .rst_n(rst_n), .bus(bus2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] segToDigit(input logic [6:0] s);
    case (s)
      7'b1000000: return 4'd0;
      7'b1111001: return 4'd1;
      7'b0100100: return 4'd2;
      7'b0110000: return 4'd3;
      7'b0011001: return 4'd4;
      7'b0010010: return 4'd5;
      7'b0000010: return 4'd6;
      7'b1111000: return 4'd7;
      7'b0000000: return 4'd8;
      7'b0010000: return 4'd9;
      default:    return 4'hF;
    endcase
  endfunction

  task automatic drive(input bit sel, input bit s, input bit u, input bit d);
    if (sel) begin
      bus2.btnS = s; bus2.btnU = u; bus2.btnD = d;
    end else begin
      bus.btnS = s; bus.btnU = u; bus.btnD = d;
    end
  endtask

  // Hold buttons for 4 cycles, release for 6; lastEdge = edge where the press acts
  task automatic press(input bit sel, input bit s, input bit u, input bit d);
    @(negedge clk);
    drive(sel, s, u, d);
    repeat (4) @(negedge clk);
    lastEdge = cyc + 2;
    drive(sel, 1'b0, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
  endtask

  task automatic waitCyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Sample 16 cycles of the scan; ok flags one-hot anodes, colon, order, coverage
  task automatic readTime(input bit sel, output logic [15:0] t, output bit ok);
    logic [3:0] a;
    logic [7:0] s;
    logic [3:0] seen;
    int idx;
    int prevIdx;
    t = 16'hFFFF;
    ok = 1'b1;
    seen = 4'b0000;
    prevIdx = -1;
    repeat (16) begin
      @(negedge clk);
      a = sel ? bus2.an : bus.an;
      s = sel ? bus2.seg : bus.seg;
      case (a)
        4'b1110: idx = 0;
        4'b1101: idx = 1;
        4'b1011: idx = 2;
        4'b0111: idx = 3;
        default: idx = -1;
      endcase
      if (idx < 0) begin
        ok = 1'b0;
      end else begin
        t[idx*4 +: 4] = segToDigit(s[6:0]);
        seen[idx] = 1'b1;
        if (s[7] !== (idx != 2)) ok = 1'b0;
        if (prevIdx >= 0 && idx != prevIdx && idx != (prevIdx + 1) % 4) ok = 1'b0;
        prevIdx = idx;
      end
    end
    if (seen !== 4'b1111) ok = 1'b0;
  endtask

  task automatic test_reset;
    logic [15:0] t;
    bit ok;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.an !== 4'b1111) begin
      miscompares++; $display("FAIL reset_an: got %b expected %b", bus.an, 4'b1111);
    end
    vectors++;
    if (bus.seg !== 8'hFF) begin
      miscompares++; $display("FAIL reset_seg: got %h expected %h", bus.seg, 8'hFF);
    end
    rst_n = 1'b1;
    readTime(1'b0, t, ok);
    vectors++;
    if (t !== 16'h0030) begin
      miscompares++; $display("FAIL reset_time: got %h expected %h", t, 16'h0030);
    end
    vectors++;
    if (ok !== 1'b1) begin
      miscompares++; $display("FAIL reset_scan_format: got %b expected %b", ok, 1'b1);
    end
  endtask

  task automatic test_glitch;
    logic [15:0] t;
    bit ok;
    @(negedge clk);
    bus.btnU = 1'b1;
    repeat (2) @(negedge clk);
    bus.btnU = 1'b0;
    @(negedge clk);
    bus.btnD = 1'b1;
    @(negedge clk);
    bus.btnD = 1'b0;
    repeat (10) @(negedge clk);
    readTime(1'b0, t, ok);
    vectors++;
    if (t !== 16'h0030) begin
      miscompares++; $display("FAIL glitch_no_press: got %h expected %h", t, 16'h0030);
    end
  endtask

  task automatic test_set_updown;
    logic [15:0] t;
    bit ok;
    press(1'b0, 1'b0, 1'b1, 1'b0);
    readTime(1'b0, t, ok);
    vectors++;
    if (t !== 16'h0031) begin
      miscompares++; $display("FAIL inc_one: got %h expected %h", t, 16'h0031);
    end
    for (int i = 0; i < 31; i++) press(1'b0, 1'b0, 1'b0, 1'b1);
    readTime(1'b0, t, ok);
    vectors++;
    if (t !== 16'h0000) begin
      miscompares++; $display("FAIL dec_to_zero: got %h expected %h", t, 16'h0000);
    end
    press(1'b0, 1'b0, 1'b0, 1'b1);
    readTime(1'b0, t, ok);
    vectors++;
    if (t !== 16'h0000) begin
      miscompares++; $display("FAIL dec_saturate: got %h expected %h", t, 16'h0000);
    end
    // Select at zero is ignored, so up still edits the preset afterwards
    press(1'b0, 1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    readTime(1'b0, t, ok);
    vectors++;
    if (t !== 16'h0001) begin
      miscompares++; $display("FAIL start_at_zero_ignored: got %h expected %h", t, 16'h0001);
    end
    for (int i = 0; i < 58; i++) press(1'b0, 1'b0, 1'b1, 1'b0);
    readTime(1'b0, t, ok);
    vectors++;
    if (t !== 16'h0059) begin
      miscompares++; $display("FAIL inc_to_59: got %h expected %h", t, 16'h0059);
    end
    press(1'b0, 1'b0, 1'b1, 1'b0);
    readTime(1'b0, t, ok);
    vectors++;
    if (t !== 16'h0100) begin
      miscompares++; $display("FAIL carry_minute: got %h expected %h", t, 16'h0100);
    end
    press(1'b0, 1'b0, 1'b1, 1'b1);
    readTime(1'b0, t, ok);
    vectors++;
    if (t !== 16'h0100) begin
      miscompares++; $display("FAIL up_down_same_cycle: got %h expected %h", t, 16'h0100);
    end
  endtask

  task automatic test_saturate_max;
    logic [15:0] t;
    bit ok;
    readTime(1'b1, t, ok);
    vectors++;
    if (t !== 16'h9959) begin
      miscompares++; $display("FAIL max_preset: got %h expected %h", t, 16'h9959);
    end
    press(1'b1, 1'b0, 1'b1, 1'b0);
    readTime(1'b1, t, ok);
    vectors++;
    if (t !== 16'h9959) begin
      miscompares++; $display("FAIL inc_saturate: got %h expected %h", t, 16'h9959);
    end
    press(1'b1, 1'b0, 1'b0, 1'b1);
    readTime(1'b1, t, ok);
    vectors++;
    if (t !== 16'h9958) begin
      miscompares++; $display("FAIL dec_from_max: got %h expected %h", t, 16'h9958);
    end
  endtask

  task automatic test_run_done;
    logic [15:0] t;
    bit ok;
    int tRun;
    int bad;
    for (int i = 0; i < 58; i++) press(1'b0, 1'b0, 1'b0, 1'b1);
    readTime(1'b0, t, ok);
    vectors++;
    if (t !== 16'h0002) begin
      miscompares++; $display("FAIL borrow_to_0002: got %h expected %h", t, 16'h0002);
    end
    press(1'b0, 1'b1, 1'b0, 1'b0);
    tRun = lastEdge;
    waitCyc(tRun + 5);
    readTime(1'b0, t, ok);
    vectors++;
    if (t !== 16'h0002) begin
      miscompares++; $display("FAIL run_first_second: got %h expected %h", t, 16'h0002);
    end
    waitCyc(tRun + 110);
    readTime(1'b0, t, ok);
    vectors++;
    if (t !== 16'h0001) begin
      miscompares++; $display("FAIL run_after_100: got %h expected %h", t, 16'h0001);
    end
    waitCyc(tRun + 205);
    readTime(1'b0, t, ok);
    vectors++;
    if (t !== 16'h0000 || ok !== 1'b1) begin
      miscompares++; $display("FAIL done_on_phase: got %h/%b expected %h/1", t, ok, 16'h0000);
    end
    waitCyc(tRun + 260);
    bad = 0;
    repeat (16) begin
      @(negedge clk);
      if (bus.an !== 4'b1111 || bus.seg !== 8'hFF) bad++;
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++; $display("FAIL done_blank_phase: got %0d lit samples expected 0", bad);
    end
    waitCyc(tRun + 310);
    readTime(1'b0, t, ok);
    vectors++;
    if (t !== 16'h0000 || ok !== 1'b1) begin
      miscompares++; $display("FAIL done_second_blink: got %h/%b expected %h/1", t, ok, 16'h0000);
    end
    press(1'b0, 1'b1, 1'b0, 1'b0);
    readTime(1'b0, t, ok);
    vectors++;
    if (t !== 16'h0002) begin
      miscompares++; $display("FAIL reload_preset: got %h expected %h", t, 16'h0002);
    end
    press(1'b0, 1'b0, 1'b1, 1'b0);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    readTime(1'b0, t, ok);
    vectors++;
    if (t !== 16'h0005) begin
      miscompares++; $display("FAIL back_in_set: got %h expected %h", t, 16'h0005);
    end
  endtask

  task automatic test_pause_resume;
    logic [15:0] t;
    bit ok;
    int tRun;
    int tPause;
    int tResume;
    press(1'b0, 1'b1, 1'b0, 1'b0);
    tRun = lastEdge;
    waitCyc(tRun + 30);
    press(1'b0, 1'b1, 1'b0, 1'b0);
    tPause = lastEdge;
    waitCyc(tPause + 50);
    readTime(1'b0, t, ok);
    vectors++;
    if (t !== 16'h0005) begin
      miscompares++; $display("FAIL pause_hold_early: got %h expected %h", t, 16'h0005);
    end
    waitCyc(tPause + 300);
    readTime(1'b0, t, ok);
    vectors++;
    if (t !== 16'h0005) begin
      miscompares++; $display("FAIL pause_hold_late: got %h expected %h", t, 16'h0005);
    end
    press(1'b0, 1'b1, 1'b0, 1'b0);
    tResume = lastEdge;
    waitCyc(tResume + 75);
    readTime(1'b0, t, ok);
    vectors++;
    if (t !== 16'h0005) begin
      miscompares++; $display("FAIL resume_full_second: got %h expected %h", t, 16'h0005);
    end
    waitCyc(tResume + 104);
    readTime(1'b0, t, ok);
    vectors++;
    if (t !== 16'h0004) begin
      miscompares++; $display("FAIL resume_decrement: got %h expected %h", t, 16'h0004);
    end
  endtask

  task automatic test_async_reset;
    logic [15:0] t;
    bit ok;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.an !== 4'b1111 || bus.seg !== 8'hFF) begin
      miscompares++; $display("FAIL async_reset_blank: got an=%b seg=%h expected an=1111 seg=ff", bus.an, bus.seg);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    readTime(1'b0, t, ok);
    vectors++;
    if (t !== 16'h0030) begin
      miscompares++; $display("FAIL reset_reload: got %h expected %h", t, 16'h0030);
    end
    repeat (150) @(negedge clk);
    readTime(1'b0, t, ok);
    vectors++;
    if (t !== 16'h0030) begin
      miscompares++; $display("FAIL reset_stays_set: got %h expected %h", t, 16'h0030);
    end
    readTime(1'b1, t, ok);
    vectors++;
    if (t !== 16'h9959) begin
      miscompares++; $display("FAIL reset_second_unit: got %h expected %h", t, 16'h9959);
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    test_reset;
    test_glitch;
    test_set_updown;
    test_saturate_max;
    test_run_done;
    test_pause_resume;
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/countdown_game.md
Name: countdown_game

Overview:
Top-level countdown-timer game for a 100 MHz board with three push-buttons and a 4-digit multiplexed seven-segment display. The player presets a MM:SS time with up/down buttons and starts, pauses or resumes it with the select button. The timer counts down once per second and flashes 00:00 when it expires. All logic runs in the single Clk100Mhz domain.

Parameters:
CLK_HZ, 100_000_000, input clock frequency; one timer tick every CLK_HZ cycles.
REFRESH_DIV, 100_000, cycles per digit-scan step (1 kHz step, 250 Hz per digit).
DEBOUNCE_CYCLES, 1_000_000, cycles a synchronized button must stay stable before it is accepted (10 ms).
START_SECONDS, 30, preset loaded at reset (00:30).

Ports:
Clk100Mhz  input  1  system clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
btnS  input  1  select/start/pause button, async, active-high.
btnU  input  1  increment button, async, active-high.
btnD  input  1  decrement button, async, active-high.
seg  output  8  active-low segments: seg[0]=a … seg[6]=g, seg[7]=dp.
an  output  4  active-low digit enables; an[3]=minutes tens (leftmost), an[0]=seconds units.

Behaviour:
- Reset (rst_n=0, async): state SET; preset = time = START_SECONDS; prescalers and scan index = 0; seg=8'hFF; an=4'b1111. All outputs are registered.
- Buttons: 2-flop synchronizer, then debounce. The debounced level changes only after the input is stable for DEBOUNCE_CYCLES. A rising edge of the debounced level gives a 1-cycle press pulse (pS, pU, pD). Holding a button does not auto-repeat.
- Time is held as BCD digits M1 M0 : S1 S0. Range 00:00 to 99:59. Seconds digits wrap 59↔00 with a borrow or carry into minutes.
- SET: pU adds 1 s, saturating at 99:59. pD subtracts 1 s, saturating at 00:00. pU and pD in the same cycle cause no change. On pS with time≠0: preset←time, clear the tick prescaler, go to RUN. pS at 00:00 is ignored.
- RUN: each prescaler wrap (CLK_HZ cycles) decrements time by 1 s. The decrement that reaches 00:00 moves to DONE in the same cycle. pS goes to PAUSE. pU and pD are ignored.
- PAUSE: time is frozen and the prescaler is held. pS clears the prescaler and returns to RUN, so the next decrement comes a full second later. pU and pD are ignored.
- DONE: time = 00:00. The display blinks at 1 Hz: on for the first half of each second, all segments off (seg=8'hFF) for the second half. pS reloads time←preset and goes to SET.
- pS together with pU/pD: pS has priority and the others are dropped.
- Display scan: the index advances every REFRESH_DIV cycles, visiting 0→1→2→3→0. Exactly one an bit is low at a time, except when blanked in DONE, where an=4'b1111.
- The dp (seg[7]=0) is lit only on digit 2 (an[2]) as the colon.
- Hex digits use the standard 7-segment map, e.g. '0'=7'b1000000, '3'=7'b0110000, '5'=7'b0010010.

Decomposition:
- Shared package game_pkg:
  - state enum {SET, RUN, PAUSE, DONE}
  - 7-segment decode function (BCD→7 bits)
  - SEG_BLANK constant = 8'hFF
- One natural sub-module: btn_debounce (synchronizer + stability counter + rising-edge pulse), instantiated three times.
- Prescalers, state machine, BCD counter and display mux stay in the top level.

Test Plan:
- Override CLK_HZ=100, REFRESH_DIV=4, DEBOUNCE_CYCLES=3.
  - Reset → an=4'b1111, seg=8'hFF, then the scan shows 0,0(dp),3,0 on an[3..0].
  - Glitches shorter than 3 cycles produce no press.
- From 00:30 in SET:
  - one pU → 00:31.
  - 31 pD → 00:00.
  - a further pD stays 00:00.
  - pS at 00:00 stays in SET.
- From 00:59 in SET:
  - pU → 01:00.
  - 99:59 + pU → 99:59.
  - pU+pD in the same cycle → unchanged.
- Set 00:02, pS:
  - after 100 cycles → 00:01.
  - after 200 cycles → DONE, with display on for 50 cycles then blank for 50.
  - pS → SET showing 00:02.
- RUN at 00:05:
  - pS at cycle 30 of the second → PAUSE, holds 00:05 indefinitely.
  - pS → next decrement exactly 100 cycles later.
- Assert rst_n low mid-RUN → outputs blank in the same cycle; on release, SET with 00:30.
